lcd_ctrl: RTL and testbench
===========================

Name: lcd_ctrl

Overview:
- Downstream consumer of the LSU's 32-bit LCD output register.
- Converts software writes to that register into HD44780-style bus cycles: data/RS/RW setup, EN pulse, hold, then execution wait.
- Drives the board LCD pins directly.
- Exposes busy and overrun status so firmware can read them back through a switch/status path.

Parameters:
- SETUP_CYC, 2, cycles RS/RW/DATA are stable before EN rises (≥1)
- EN_CYC, 13, EN high-pulse width in cycles (≥1; 260 ns at 50 MHz)
- HOLD_CYC, 2, cycles DATA/RS/RW are held after EN falls (≥1)
- EXEC_CYC, 2000, post-transfer execution wait, normal commands (≥1; 40 µs)
- LONG_CYC, 82000, post-transfer wait for clear/home (≥1; 1.64 ms; used only with the optional feature)
- CNT_W, 17, timer counter width; must hold max(all *_CYC)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous active-low reset
- i_lcd_reg  in  32  LCD register from the LSU: [7:0] DATA, [8] RS, [9] RW, [10] TOGGLE, [31] ON
- o_lcd_data  out  8  LCD data bus
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  read/write (driven only; no bus reads)
- o_lcd_en  out  1  enable strobe
- o_lcd_on  out  1  LCD power/backlight
- o_busy  out  1  transfer in progress or command pending
- o_overrun  out  1  sticky: a pending command was overwritten

Behaviour:
- Clock/reset: one clock, i_clk. Reset i_reset is asynchronous, active-low.
- Reset values: every output is 0. Internal state: t_last=0, pending_v=0, state=IDLE, timer=0.
- Reset mid-transfer: o_lcd_en drops immediately (asynchronously) and the transfer is abandoned.
- o_lcd_on: registered copy of i_lcd_reg[31], updated every cycle, independent of the FSM.
- Trigger: a command is issued when i_lcd_reg[10] != t_last. On detection, t_last <= i_lcd_reg[10]; {RW,RS,DATA} are captured the same cycle. Rewriting the same toggle value issues nothing, so firmware flips TOGGLE once per command.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. The timer loads N-1 on entry to each state; the state exits when the timer reaches 0.
- IDLE + trigger: load output regs, go to SETUP next cycle. o_busy=1 from the cycle after detection.
- SETUP: o_lcd_en=0, outputs stable for SETUP_CYC cycles, then PULSE.
- PULSE: o_lcd_en=1 for exactly EN_CYC cycles, then HOLD.
- HOLD: o_lcd_en=0, outputs stable for HOLD_CYC cycles, then WAIT.
- WAIT: lasts EXEC_CYC cycles (or LONG_CYC, see Optional Feature). Outputs keep their last value.
- At WAIT end:
  - pending_v=1: load the pending command into the output regs, clear pending_v, go to SETUP.
  - otherwise: go to IDLE, o_busy=0.
- Trigger while not IDLE: captured into a one-deep pending buffer and pending_v set.
  - If pending_v is already 1, the buffer is overwritten with the newer command and o_overrun is set. o_overrun clears only on reset.
- Trigger on the same cycle WAIT ends: the new command goes straight to SETUP. The pending buffer is bypassed.
- o_busy = (state != IDLE) | pending_v.
- Max back-to-back throughput: one command per SETUP+EN+HOLD+WAIT cycles. No IDLE bubble between queued commands.

Optional Feature:
- Macro: LCD_LONGCMD_EN.
- Defined: commands with RS=0 and DATA in {0x01, 0x02, 0x03} (clear display, return home) use LONG_CYC in WAIT. All other commands use EXEC_CYC.
- Undefined: every command uses EXEC_CYC; LONG_CYC is unused; the comparison logic is not built.

Test Plan:
Bench overrides: SETUP_CYC=2, EN_CYC=4, HOLD_CYC=2, EXEC_CYC=10, LONG_CYC=50.
1. Reset, then i_lcd_reg=0x8000_0441 (ON, TOGGLE=1, RS=0, DATA=0x41) -> o_lcd_on=1 next cycle; o_lcd_data=0x41, rs=0; EN high exactly 4 cycles starting 3 cycles after the write; o_busy falls 18 cycles after the write.
2. Write 0x8000_0541, then 0x8000_0541 again (same toggle) -> exactly one EN pulse, rs=1.
3. Issue A (DATA=0x10), flip toggle with B (0x20) during PULSE, flip again with C (0x30) during WAIT -> two EN pulses (A then C); o_overrun=1; o_busy stays high continuously until C's WAIT ends.
4. Issue a command, then toggle again exactly on the last WAIT cycle -> second SETUP starts on the next cycle with the new data; o_overrun stays 0.
5. Assert i_reset low mid-PULSE -> o_lcd_en, o_busy and o_lcd_data drop to 0 without waiting for a clock edge. After release, writing TOGGLE=1 issues a fresh command.
6. With LCD_LONGCMD_EN: command DATA=0x01, RS=0 -> o_busy high 58 cycles (8+50). DATA=0x01, RS=1 -> 18 cycles. Without the macro: both 18 cycles.

Source files
------------

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns toggle-handshaked writes to the LSU LCD register into
// HD44780-style bus cycles (setup, EN pulse, hold, execution wait), with a
// one-deep pending buffer and sticky overrun flag.
// Optional build macro LCD_LONGCMD_EN: clear/home commands (RS=0, DATA 0x01..0x03)
// use the longer LONG_CYC execution wait instead of EXEC_CYC.
module lcd_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 13,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2000,
  parameter int LONG_CYC  = 82000,
  parameter int CNT_W     = 17
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_reg,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } state_t;

  // Every phase length must be at least one cycle and fit the timer.
  if (CNT_W < 1 || CNT_W > 30 ||
      SETUP_CYC < 1 || EN_CYC < 1 || HOLD_CYC < 1 ||
      EXEC_CYC < 1 || LONG_CYC < 1 ||
      SETUP_CYC > (1 << CNT_W) || EN_CYC > (1 << CNT_W) ||
      HOLD_CYC > (1 << CNT_W) || EXEC_CYC > (1 << CNT_W) ||
      LONG_CYC > (1 << CNT_W)) begin : g_bad_param
    $error("lcd_ctrl: illegal cycle parameters for CNT_W");
  end

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             t_last;
  logic             pending_v;
  logic [9:0]       pend_cmd;
  logic [9:0]       new_cmd;
  logic             trig;
  logic             timer_done;
  logic             wait_end;
  logic             accept_now;
  logic             capture;
  logic [CNT_W-1:0] wait_load;
  logic             unused_bits;

  // Bits 30:11 of the LSU register carry nothing for the LCD.
  assign unused_bits = ^i_lcd_reg[30:11];

  assign new_cmd    = i_lcd_reg[9:0];
  assign trig       = (i_lcd_reg[10] != t_last);
  assign timer_done = (timer == '0);
  assign wait_end   = (state == WAIT) && timer_done;
  // A new command starts directly when idle, or when it lands on the last
  // WAIT cycle with nothing queued; otherwise it goes to the pending buffer.
  assign accept_now = trig && ((state == IDLE) || (wait_end && !pending_v));
  assign capture    = trig && !accept_now;

`ifdef LCD_LONGCMD_EN
  logic long_cmd;
  assign long_cmd  = !o_lcd_rs &&
                     ((o_lcd_data == 8'h01) || (o_lcd_data == 8'h02) ||
                      (o_lcd_data == 8'h03));
  assign wait_load = long_cmd ? CNT_W'(LONG_CYC - 1) : CNT_W'(EXEC_CYC - 1);
`else
  assign wait_load = CNT_W'(EXEC_CYC - 1);
`endif

  assign o_busy = (state != IDLE) || pending_v;

  // Power/backlight follows the register bit every cycle, outside the FSM.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_lcd_on <= 1'b0;
    end else begin
      o_lcd_on <= i_lcd_reg[31];
    end
  end

  // Bus-cycle FSM with phase timer, toggle detection and pending buffer.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      timer      <= '0;
      t_last     <= 1'b0;
      pending_v  <= 1'b0;
      pend_cmd   <= '0;
      o_lcd_data <= '0;
      o_lcd_rs   <= 1'b0;
      o_lcd_rw   <= 1'b0;
      o_lcd_en   <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      if (trig) begin
        t_last <= i_lcd_reg[10];
      end

      case (state)
        IDLE: begin
          if (trig) begin
            {o_lcd_rw, o_lcd_rs, o_lcd_data} <= new_cmd;
            state <= SETUP;
            timer <= CNT_W'(SETUP_CYC - 1);
          end
        end
        SETUP: begin
          if (timer_done) begin
            state    <= PULSE;
            timer    <= CNT_W'(EN_CYC - 1);
            o_lcd_en <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        PULSE: begin
          if (timer_done) begin
            state    <= HOLD;
            timer    <= CNT_W'(HOLD_CYC - 1);
            o_lcd_en <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        HOLD: begin
          if (timer_done) begin
            state <= WAIT;
            timer <= wait_load;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        WAIT: begin
          if (timer_done) begin
            if (pending_v) begin
              {o_lcd_rw, o_lcd_rs, o_lcd_data} <= pend_cmd;
              pending_v <= 1'b0;
              state     <= SETUP;
              timer     <= CNT_W'(SETUP_CYC - 1);
            end else if (trig) begin
              {o_lcd_rw, o_lcd_rs, o_lcd_data} <= new_cmd;
              state <= SETUP;
              timer <= CNT_W'(SETUP_CYC - 1);
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase

      // A queued command consumed this cycle frees the buffer, so only a
      // still-occupied buffer counts as an overrun.
      if (capture) begin
        pend_cmd  <= new_cmd;
        pending_v <= 1'b1;
        if (pending_v && !wait_end) begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed self-checking bench for lcd_ctrl with shortened timing
// (SETUP=2, EN=4, HOLD=2, EXEC=10, LONG=50).
module tb_lcd_ctrl;

  localparam int SHORT_BUSY = 2 + 4 + 2 + 10;
`ifdef LCD_LONGCMD_EN
  localparam int LONG_BUSY = 2 + 4 + 2 + 50;
`else
  localparam int LONG_BUSY = SHORT_BUSY;
`endif

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_lcd_reg;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;
  logic        o_busy;
  logic        o_overrun;

  int total;
  int bad;

  int   w_rise1, w_rise2, w_pulses, w_en_cnt, w_busy_cnt;
  logic [7:0] w_data1, w_data2;
  logic w_rs1, w_rw1, w_on1, w_busy1;

  lcd_ctrl #(
    .SETUP_CYC(2),
    .EN_CYC   (4),
    .HOLD_CYC (2),
    .EXEC_CYC (10),
    .LONG_CYC (50),
    .CNT_W    (17)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_lcd_reg (i_lcd_reg),
    .o_lcd_data(o_lcd_data),
    .o_lcd_rs  (o_lcd_rs),
    .o_lcd_rw  (o_lcd_rw),
    .o_lcd_en  (o_lcd_en),
    .o_lcd_on  (o_lcd_on),
    .o_busy    (o_busy),
    .o_overrun (o_overrun)
  );

  // Free-running 100 MHz-style clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Short asynchronous reset pulse between clock edges; leaves toggle at 0.
  task automatic apply_reset();
    @(posedge i_clk);
    #1;
    i_reset   = 1'b0;
    i_lcd_reg = 32'h0;
    #2;
    i_reset   = 1'b1;
  endtask

  // Steps cycles after a write (cycle 1 = first edge that sees it), records
  // EN pulses and busy length, and applies up to two register writes at the
  // given cycle numbers. Stops once busy falls after the last scheduled write.
  task automatic watch(input int max_cyc,
                       input int e1k, input logic [31:0] e1v,
                       input int e2k, input logic [31:0] e2v);
    logic prev_en;
    int   last_ev;
    w_rise1 = 0; w_rise2 = 0; w_pulses = 0; w_en_cnt = 0; w_busy_cnt = 0;
    w_data1 = 8'h0; w_data2 = 8'h0; w_rs1 = 1'b0;
    w_rw1 = 1'b0; w_on1 = 1'b0; w_busy1 = 1'b0;
    prev_en = o_lcd_en;
    last_ev = (e1k > e2k) ? e1k : e2k;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge i_clk);
      #1;
      if (k == 1) begin
        w_on1   = o_lcd_on;
        w_busy1 = o_busy;
        w_rw1   = o_lcd_rw;
      end
      if (o_lcd_en && !prev_en) begin
        w_pulses++;
        if (w_pulses == 1) begin
          w_rise1 = k;
          w_data1 = o_lcd_data;
          w_rs1   = o_lcd_rs;
        end else if (w_pulses == 2) begin
          w_rise2 = k;
          w_data2 = o_lcd_data;
        end
      end
      prev_en = o_lcd_en;
      if (o_lcd_en) w_en_cnt++;
      if (o_busy) begin
        w_busy_cnt++;
      end else if (w_busy_cnt > 0 && k > last_ev) begin
        break;
      end
      if (k == e1k) i_lcd_reg = e1v;
      if (k == e2k) i_lcd_reg = e2v;
    end
  endtask

  task automatic test_reset();
    i_reset   = 1'b0;
    i_lcd_reg = 32'h8000_0441;
    repeat (3) @(posedge i_clk);
    #1;
    total++; if (o_lcd_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h expected 00", o_lcd_data); end
    total++; if (o_lcd_rs !== 1'b0) begin bad++; $display("[TB] FAIL reset_rs: got %b expected 0", o_lcd_rs); end
    total++; if (o_lcd_rw !== 1'b0) begin bad++; $display("[TB] FAIL reset_rw: got %b expected 0", o_lcd_rw); end
    total++; if (o_lcd_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_en: got %b expected 0", o_lcd_en); end
    total++; if (o_lcd_on !== 1'b0) begin bad++; $display("[TB] FAIL reset_on: got %b expected 0", o_lcd_on); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun: got %b expected 0", o_overrun); end
    i_lcd_reg = 32'h0;
    i_reset   = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_single();
    apply_reset();
    i_lcd_reg = 32'h8000_0441;
    watch(60, -1, 32'h0, -1, 32'h0);
    total++; if (w_on1 !== 1'b1) begin bad++; $display("[TB] FAIL single_on: got %b expected 1", w_on1); end
    total++; if (w_busy1 !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_start: got %b expected 1", w_busy1); end
    total++; if (w_rw1 !== 1'b0) begin bad++; $display("[TB] FAIL single_rw: got %b expected 0", w_rw1); end
    total++; if (w_rise1 != 3) begin bad++; $display("[TB] FAIL single_en_rise: got %0d expected 3", w_rise1); end
    total++; if (w_en_cnt != 4) begin bad++; $display("[TB] FAIL single_en_width: got %0d expected 4", w_en_cnt); end
    total++; if (w_pulses != 1) begin bad++; $display("[TB] FAIL single_pulses: got %0d expected 1", w_pulses); end
    total++; if (w_data1 !== 8'h41) begin bad++; $display("[TB] FAIL single_data: got %h expected 41", w_data1); end
    total++; if (w_rs1 !== 1'b0) begin bad++; $display("[TB] FAIL single_rs: got %b expected 0", w_rs1); end
    total++; if (w_busy_cnt != SHORT_BUSY) begin bad++; $display("[TB] FAIL single_busy_len: got %0d expected %0d", w_busy_cnt, SHORT_BUSY); end
  endtask

  task automatic test_same_toggle();
    apply_reset();
    i_lcd_reg = 32'h8000_0541;
    watch(60, 5, 32'h8000_0541, 12, 32'h8000_0541);
    total++; if (w_pulses != 1) begin bad++; $display("[TB] FAIL same_toggle_pulses: got %0d expected 1", w_pulses); end
    total++; if (w_rs1 !== 1'b1) begin bad++; $display("[TB] FAIL same_toggle_rs: got %b expected 1", w_rs1); end
    total++; if (w_busy_cnt != SHORT_BUSY) begin bad++; $display("[TB] FAIL same_toggle_busy_len: got %0d expected %0d", w_busy_cnt, SHORT_BUSY); end
  endtask

  task automatic test_overrun();
    // Toggle is 1 from the previous test: A flips to 0, B to 1, C to 0.
    i_lcd_reg = 32'h8000_0010;
    watch(100, 4, 32'h8000_0420, 12, 32'h8000_0030);
    total++; if (w_pulses != 2) begin bad++; $display("[TB] FAIL overrun_pulses: got %0d expected 2", w_pulses); end
    total++; if (w_data1 !== 8'h10) begin bad++; $display("[TB] FAIL overrun_first_data: got %h expected 10", w_data1); end
    total++; if (w_data2 !== 8'h30) begin bad++; $display("[TB] FAIL overrun_second_data: got %h expected 30", w_data2); end
    total++; if (w_rise2 != 21) begin bad++; $display("[TB] FAIL overrun_second_rise: got %0d expected 21", w_rise2); end
    total++; if (w_busy_cnt != 2 * SHORT_BUSY) begin bad++; $display("[TB] FAIL overrun_busy_len: got %0d expected %0d", w_busy_cnt, 2 * SHORT_BUSY); end
    total++; if (o_overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun_flag: got %b expected 1", o_overrun); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    i_lcd_reg = 32'h8000_0455;
    watch(100, 18, 32'h8000_0066, -1, 32'h0);
    total++; if (w_pulses != 2) begin bad++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", w_pulses); end
    total++; if (w_rise2 != 21) begin bad++; $display("[TB] FAIL b2b_second_rise: got %0d expected 21", w_rise2); end
    total++; if (w_data2 !== 8'h66) begin bad++; $display("[TB] FAIL b2b_second_data: got %h expected 66", w_data2); end
    total++; if (w_busy_cnt != 2 * SHORT_BUSY) begin bad++; $display("[TB] FAIL b2b_busy_len: got %0d expected %0d", w_busy_cnt, 2 * SHORT_BUSY); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("[TB] FAIL b2b_overrun: got %b expected 0", o_overrun); end
  endtask

  task automatic test_reset_mid_pulse();
    apply_reset();
    i_lcd_reg = 32'h8000_0477;
    repeat (4) @(posedge i_clk);
    #1;
    total++; if (o_lcd_en !== 1'b1) begin bad++; $display("[TB] FAIL midpulse_en_before: got %b expected 1", o_lcd_en); end
    #2;
    i_reset = 1'b0;
    #1;
    total++; if (o_lcd_en !== 1'b0) begin bad++; $display("[TB] FAIL midpulse_en_async: got %b expected 0", o_lcd_en); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL midpulse_busy_async: got %b expected 0", o_busy); end
    total++; if (o_lcd_data !== 8'h00) begin bad++; $display("[TB] FAIL midpulse_data_async: got %h expected 00", o_lcd_data); end
    i_lcd_reg = 32'h8000_0488;
    #1;
    i_reset = 1'b1;
    watch(60, -1, 32'h0, -1, 32'h0);
    total++; if (w_pulses != 1) begin bad++; $display("[TB] FAIL after_reset_pulses: got %0d expected 1", w_pulses); end
    total++; if (w_rise1 != 3) begin bad++; $display("[TB] FAIL after_reset_rise: got %0d expected 3", w_rise1); end
    total++; if (w_data1 !== 8'h88) begin bad++; $display("[TB] FAIL after_reset_data: got %h expected 88", w_data1); end
    total++; if (w_busy_cnt != SHORT_BUSY) begin bad++; $display("[TB] FAIL after_reset_busy_len: got %0d expected %0d", w_busy_cnt, SHORT_BUSY); end
  endtask

  task automatic test_long_cmd();
    apply_reset();
    i_lcd_reg = 32'h8000_0401;
    watch(200, -1, 32'h0, -1, 32'h0);
    total++; if (w_busy_cnt != LONG_BUSY) begin bad++; $display("[TB] FAIL long_clear_busy: got %0d expected %0d", w_busy_cnt, LONG_BUSY); end
    i_lcd_reg = 32'h8000_0101;
    watch(200, -1, 32'h0, -1, 32'h0);
    total++; if (w_busy_cnt != SHORT_BUSY) begin bad++; $display("[TB] FAIL long_rs1_busy: got %0d expected %0d", w_busy_cnt, SHORT_BUSY); end
    i_lcd_reg = 32'h8000_0403;
    watch(200, -1, 32'h0, -1, 32'h0);
    total++; if (w_busy_cnt != LONG_BUSY) begin bad++; $display("[TB] FAIL long_home_busy: got %0d expected %0d", w_busy_cnt, LONG_BUSY); end
    i_lcd_reg = 32'h8000_0004;
    watch(200, -1, 32'h0, -1, 32'h0);
    total++; if (w_busy_cnt != SHORT_BUSY) begin bad++; $display("[TB] FAIL long_04_busy: got %0d expected %0d", w_busy_cnt, SHORT_BUSY); end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    total     = 0;
    bad       = 0;
    i_reset   = 1'b0;
    i_lcd_reg = 32'h0;
    test_reset();
    test_single();
    test_same_toggle();
    test_overrun();
    test_back_to_back();
    test_reset_mid_pulse();
    test_long_cmd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
